// File: rtl/regfile_pkg.sv
// Shared register-file constants and the command/state encodings used by its
// access controller.
package regfile_pkg;

    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 32;
    localparam int NUM_REGS   = 32;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_DUMP  = 2'd2,
        OP_CLEAR = 2'd3
    } cmd_op_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_WR      = 3'd2,
        ST_DUMP_RD = 3'd3,
        ST_CLR     = 3'd4,
        ST_RESP    = 3'd5
    } ctrl_state_t;

endpackage

// File: rtl/regfile_access_ctrl.sv
// Command-driven initiator for the register file write port and first read port:
// single read/write, full dump and clear, each answered on a response channel.
module regfile_access_ctrl #(
    parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
    parameter int NUM_REGS   = regfile_pkg::NUM_REGS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic                  rsp_last,
    output logic                  busy,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_wa,
    output logic [DATA_WIDTH-1:0] rf_wd,
    output logic [ADDR_WIDTH-1:0] rf_ra,
    input  logic [DATA_WIDTH-1:0] rf_rd
);
    import regfile_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

    ctrl_state_t           state_q, state_d;
    cmd_op_t               op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_last_q, rsp_last_d;

    // Asynchronous reset: an in-flight command is abandoned outright.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_READ;
            addr_q     <= '0;
            data_q     <= '0;
            idx_q      <= '0;
            rsp_addr_q <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            rsp_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            idx_q      <= idx_d;
            rsp_addr_q <= rsp_addr_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            rsp_last_q <= rsp_last_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        data_d     = data_q;
        idx_d      = idx_q;
        rsp_addr_d = rsp_addr_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        rsp_last_d = rsp_last_q;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rf_we      = 1'b0;
        rf_wa      = '0;
        rf_wd      = '0;
        rf_ra      = '0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d   = cmd_op_t'(cmd_op);
                    addr_d = cmd_addr;
                    data_d = cmd_data;
                    case (cmd_op_t'(cmd_op))
                        OP_READ:  state_d = ST_RD;
                        OP_WRITE: state_d = ST_WR;
                        OP_DUMP: begin
                            idx_d   = '0;
                            state_d = ST_DUMP_RD;
                        end
                        default: begin
                            // Register 0 is hardwired, so clearing starts at 1.
                            idx_d   = ADDR_WIDTH'(1);
                            state_d = ST_CLR;
                        end
                    endcase
                end
            end

            ST_RD: begin
                rf_ra      = addr_q;
                rsp_addr_d = addr_q;
                rsp_data_d = rf_rd;
                rsp_err_d  = 1'b0;
                rsp_last_d = 1'b1;
                state_d    = ST_RESP;
            end

            ST_WR: begin
                rsp_addr_d = addr_q;
                rsp_last_d = 1'b1;
                if (addr_q != '0) begin
                    rf_we      = 1'b1;
                    rf_wa      = addr_q;
                    rf_wd      = data_q;
                    rsp_data_d = data_q;
                    rsp_err_d  = 1'b0;
                end else begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                end
                state_d = ST_RESP;
            end

            ST_DUMP_RD: begin
                rf_ra      = idx_q;
                rsp_addr_d = idx_q;
                rsp_data_d = rf_rd;
                rsp_err_d  = 1'b0;
                rsp_last_d = (idx_q == LAST_IDX);
                state_d    = ST_RESP;
            end

            ST_CLR: begin
                rf_we = 1'b1;
                rf_wa = idx_q;
                if (idx_q == LAST_IDX) begin
                    rsp_addr_d = LAST_IDX;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                    rsp_last_d = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    idx_d = idx_q + ADDR_WIDTH'(1);
                end
            end

            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    if (op_q == OP_DUMP && !rsp_last_q) begin
                        idx_d   = idx_q + ADDR_WIDTH'(1);
                        state_d = ST_DUMP_RD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign busy     = (state_q != ST_IDLE);
    assign rsp_addr = rsp_addr_q;
    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;
    assign rsp_last = rsp_last_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Closed-loop bench: controller plus a behavioural 32x32 register file, with a
// scoreboard of expected responses filled as commands are issued.
module tb_regfile_access_ctrl;
    import regfile_pkg::*;

    localparam int AW = ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int NR = NUM_REGS;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_data = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          rsp_last;
    logic          busy;
    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;
    logic [AW-1:0] rf_ra;
    logic [DW-1:0] rf_rd;

    always #5 clk = ~clk;

    regfile_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_last(rsp_last),
        .busy(busy), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .rf_ra(rf_ra), .rf_rd(rf_rd)
    );

    // Register file: register 0 reads zero, writes land on posedge, no reset.
    logic [DW-1:0] rf_mem [NR];
    always @(posedge clk) if (rf_we && rf_wa != '0) rf_mem[rf_wa] <= rf_wd;
    assign rf_rd = (rf_ra == '0) ? '0 : rf_mem[rf_ra];

    // Write-port activity as the register file sees it.
    int we_cnt = 0, we_sum = 0, we_nz_cnt = 0, cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rf_we) begin
            we_cnt = we_cnt + 1;
            we_sum = we_sum + int'(rf_wa);
            if (rf_wd != '0) we_nz_cnt = we_nz_cnt + 1;
        end
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          err;
        logic          last;
    } rsp_t;
    rsp_t          exp_q[$];
    logic [DW-1:0] shadow [NR];
    int            pass_cnt = 0, check_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic e, input logic l);
        rsp_t r;
        r.addr = a; r.data = d; r.err = e; r.last = l;
        exp_q.push_back(r);
    endtask

    // Compare current response outputs with the scoreboard head; pop if consumed.
    task automatic cmp_front(input string tag, input bit pop);
        rsp_t r;
        check({tag, "_qnonempty"}, (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            r = exp_q[0];
            if (pop) void'(exp_q.pop_front());
            check({tag, "_addr"}, rsp_addr, r.addr);
            check({tag, "_data"}, rsp_data, r.data);
            check({tag, "_err"},  rsp_err,  r.err);
            check({tag, "_last"}, rsp_last, r.last);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge,
    // with acc = number of posedges up to and including acceptance.
    task automatic send_cmd(input cmd_op_t op, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, output int acc);
        bit ok = 0;
        cmd_op = op; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        check("accept_wait", ok, 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        acc = cyc;
        $display("cmd op=%0d addr=%0d data=0x%08h accepted at cycle %0d", op, a, d, acc);
    endtask

    // Wait for a single-response command result; lat counts posedges after acceptance.
    task automatic get_rsp(input string tag, input int acc, input int lat);
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (rsp_valid) begin ok = 1; break; end
            @(negedge clk);
        end
        check({tag, "_rsp_wait"}, ok, 1);
        if (ok) begin
            if (lat >= 0) check({tag, "_latency"}, cyc - acc, lat);
            $display("rsp %s addr=%0d data=0x%08h err=%0b last=%0b", tag, rsp_addr, rsp_data, rsp_err, rsp_last);
            cmp_front(tag, 1);
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            check({tag, "_idle_valid"}, rsp_valid, 0);
            check({tag, "_idle_ready"}, cmd_ready, 1);
        end
    endtask

    task automatic preload();
        int acc;
        for (int i = 1; i < NR; i++) begin
            push_exp(AW'(i), DW'(32'h100 + i), 1'b0, 1'b1);
            send_cmd(OP_WRITE, AW'(i), DW'(32'h100 + i), acc);
            get_rsp("preload", acc, 1);
            shadow[i] = DW'(32'h100 + i);
        end
    endtask

    task automatic run_dump(input string tag, input bit toggle, input bit hold_read);
        int acc, got = 0, ready_seen = 0, last_cyc;
        for (int i = 0; i < NR; i++) push_exp(AW'(i), shadow[i], 1'b0, (i == NR - 1));
        send_cmd(OP_DUMP, '0, '0, acc);
        if (hold_read) begin
            cmd_op = OP_READ; cmd_addr = AW'(7); cmd_data = '0; cmd_valid = 1'b1;
            push_exp(AW'(7), shadow[7], 1'b0, 1'b1);
        end
        for (int i = 0; i < 400 && got < NR; i++) begin
            rsp_ready = toggle ? ~rsp_ready : 1'b1;
            if (cmd_ready) ready_seen++;
            if (rsp_valid) begin
                if (rsp_ready) begin
                    $display("rsp %s addr=%0d data=0x%08h last=%0b", tag, rsp_addr, rsp_data, rsp_last);
                    cmp_front(tag, 1);
                    got++;
                end else begin
                    cmp_front({tag, "_stall"}, 0);
                end
            end
            @(negedge clk);
        end
        last_cyc = cyc;
        rsp_ready = 1'b0;
        check({tag, "_count"}, got, NR);
        check({tag, "_ready_while_busy"}, ready_seen, 0);
        check({tag, "_ready_after"}, cmd_ready, 1);
        if (!toggle) check({tag, "_cycles"}, last_cyc - acc, 64);
        if (hold_read) begin
            @(posedge clk);
            @(negedge clk);
            cmd_valid = 1'b0;
            acc = cyc;
            get_rsp({tag, "_held_read"}, acc, 1);
            ready_seen = 0;
            repeat (4) begin
                if (rsp_valid) ready_seen++;
                @(negedge clk);
            end
            check({tag, "_held_read_once"}, ready_seen, 0);
            check({tag, "_q_empty"}, exp_q.size(), 0);
        end
    endtask

    initial begin
        int acc, we0, sum0, nz0, bad;
        for (int i = 0; i < NR; i++) shadow[i] = '0;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rf_we", rf_we, 0);
        check("rst_rsp_bits", {rsp_addr, rsp_err, rsp_last}, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rf_ports", {rf_wa, rf_ra}, 0);
        #2 reset = 1'b1;
        @(negedge clk);

        // WRITE 5 then READ 5; WRITE lands on the posedge before rsp_valid shows.
        push_exp(AW'(5), 32'hDEADBEEF, 1'b0, 1'b1);
        send_cmd(OP_WRITE, AW'(5), 32'hDEADBEEF, acc);
        check("wr5_we", rf_we, 1);
        check("wr5_wa", rf_wa, 5);
        check("wr5_wd", rf_wd, 32'hDEADBEEF);
        check("wr5_early_valid", rsp_valid, 0);
        get_rsp("wr5", acc, 1);
        shadow[5] = 32'hDEADBEEF;
        push_exp(AW'(5), shadow[5], 1'b0, 1'b1);
        send_cmd(OP_READ, AW'(5), '0, acc);
        check("rd5_ra", rf_ra, 5);
        check("rd5_we", rf_we, 0);
        get_rsp("rd5", acc, 1);

        // WRITE to register 0 is rejected.
        we0 = we_cnt;
        push_exp('0, '0, 1'b1, 1'b1);
        send_cmd(OP_WRITE, '0, 32'h12345678, acc);
        check("wr0_we", rf_we, 0);
        get_rsp("wr0", acc, 1);
        check("wr0_no_write", we_cnt - we0, 0);
        push_exp('0, '0, 1'b0, 1'b1);
        send_cmd(OP_READ, '0, '0, acc);
        get_rsp("rd0", acc, 1);

        // DUMP with back-pressure and a READ waiting behind it.
        preload();
        run_dump("dump_tog", 1'b1, 1'b1);

        // Full CLEAR.
        preload();
        we0 = we_cnt; sum0 = we_sum; nz0 = we_nz_cnt;
        push_exp(AW'(NR - 1), '0, 1'b0, 1'b1);
        send_cmd(OP_CLEAR, '0, 32'hFFFFFFFF, acc);
        get_rsp("clr", acc, 31);
        check("clr_we_count", we_cnt - we0, 31);
        check("clr_we_addr_sum", we_sum - sum0, 496);
        check("clr_we_nonzero", we_nz_cnt - nz0, 0);
        for (int i = 0; i < NR; i++) shadow[i] = '0;
        run_dump("dump_zero", 1'b0, 1'b0);

        // Reset during the 10th CLEAR cycle.
        preload();
        we0 = we_cnt;
        send_cmd(OP_CLEAR, '0, '0, acc);
        repeat (9) @(negedge clk);
        check("abort_pre_we", rf_we, 1);
        check("abort_pre_wa", rf_wa, 10);
        #2 reset = 1'b0;
        #1;
        check("abort_rf_we", rf_we, 0);
        check("abort_busy", busy, 0);
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_rsp_bits", {rsp_addr, rsp_err, rsp_last}, 0);
        check("abort_rf_ports", {rf_wa, rf_ra}, 0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid || busy || !cmd_ready) bad++;
        end
        check("abort_quiet", bad, 0);
        check("abort_we_count", we_cnt - we0, 9);
        for (int i = 1; i < 10; i++) shadow[i] = '0;
        run_dump("dump_abort", 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
